// File: rtl/t03_fpga_cfg_streamer_if.sv
// SRAM read port and configuration chain bundle for the FPGA config streamer.
// The master side (the streamer) drives the request and the serial chain.
interface t03_fpga_cfg_streamer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  sram_csb;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_dout;
  logic                  cfg_bit;
  logic                  cfg_shift;
  logic                  cfg_latch;

  modport master (
    output sram_csb,
    output sram_addr,
    input  sram_dout,
    output cfg_bit,
    output cfg_shift,
    output cfg_latch
  );

  modport slave (
    input  sram_csb,
    input  sram_addr,
    output sram_dout,
    input  cfg_bit,
    input  cfg_shift,
    input  cfg_latch
  );
endinterface

// File: rtl/t03_fpga_cfg_streamer.sv
// Streams word_count SRAM words MSB-first onto the fabric config chain, then pulses cfg_latch.
// Optional macro CFG_CHECKSUM_EN adds a trailing XOR-checksum word read that gates the latch.
module t03_fpga_cfg_streamer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned SHIFT_DIV  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  t03_fpga_cfg_streamer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int unsigned DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]      words_left_q, words_left_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;

  logic                  sram_csb_q, sram_csb_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                  cfg_bit_q, cfg_bit_d;
  logic                  cfg_shift_q, cfg_shift_d;
  logic                  cfg_latch_q, cfg_latch_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  period_end;
  logic                  word_end;

`ifdef CFG_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] xor_q, xor_d;
  logic                  chk_q, chk_d;
  logic                  cfg_err_q, cfg_err_d;
`endif

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    words_left_d = words_left_q;
    shreg_d      = shreg_q;
    div_d        = div_q;
    bit_d        = bit_q;
`ifdef CFG_CHECKSUM_EN
    xor_d        = xor_q;
    chk_d        = chk_q;
    cfg_err_d    = cfg_err_q;
`endif

    period_end = (div_q == DIV_W'(SHIFT_DIV - 1));
    word_end   = period_end && (bit_q == BIT_W'(DATA_WIDTH - 1));

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_addr_d   = start_addr;
          words_left_d = word_count;
`ifdef CFG_CHECKSUM_EN
          xor_d        = '0;
          chk_d        = 1'b0;
          cfg_err_d    = 1'b0;
`endif
          state_d      = (word_count == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: state_d = S_WAIT;

      S_WAIT: begin
`ifdef CFG_CHECKSUM_EN
        if (chk_q) begin
          // Trailing checksum word: compared, never shifted
          cfg_err_d = (bus.sram_dout != xor_q);
          state_d   = (bus.sram_dout == xor_q) ? S_LATCH : S_DONE;
        end else begin
          shreg_d = bus.sram_dout;
          xor_d   = xor_q ^ bus.sram_dout;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
`else
        shreg_d = bus.sram_dout;
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
`endif
      end

      S_SHIFT: begin
        // Pulse occupies the first cycle of each divider period; shift after it
        if (div_q == '0) begin
          shreg_d = {shreg_q[DATA_WIDTH-2:0], 1'b0};
        end
        if (period_end) begin
          div_d = '0;
          bit_d = bit_q + BIT_W'(1);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (word_end) begin
          if (words_left_q == CNT_W'(1)) begin
`ifdef CFG_CHECKSUM_EN
            cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
            chk_d      = 1'b1;
            state_d    = S_FETCH;
`else
            state_d    = S_LATCH;
`endif
          end else begin
            words_left_d = words_left_q - CNT_W'(1);
            cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
            state_d      = S_FETCH;
          end
        end
      end

      S_LATCH: state_d = S_DONE;

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the upcoming state so they line up with it
    sram_csb_d  = (state_d != S_FETCH);
    sram_addr_d = (state_d == S_FETCH) ? cur_addr_d : sram_addr_q;
    cfg_shift_d = (state_d == S_SHIFT) && (div_d == '0);
    cfg_bit_d   = cfg_shift_d & shreg_d[DATA_WIDTH-1];
    cfg_latch_d = (state_d == S_LATCH);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      words_left_q <= '0;
      shreg_q      <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      sram_csb_q   <= 1'b1;
      sram_addr_q  <= '0;
      cfg_bit_q    <= 1'b0;
      cfg_shift_q  <= 1'b0;
      cfg_latch_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      xor_q        <= '0;
      chk_q        <= 1'b0;
      cfg_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      words_left_q <= words_left_d;
      shreg_q      <= shreg_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      sram_csb_q   <= sram_csb_d;
      sram_addr_q  <= sram_addr_d;
      cfg_bit_q    <= cfg_bit_d;
      cfg_shift_q  <= cfg_shift_d;
      cfg_latch_q  <= cfg_latch_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef CFG_CHECKSUM_EN
      xor_q        <= xor_d;
      chk_q        <= chk_d;
      cfg_err_q    <= cfg_err_d;
`endif
    end
  end

  assign bus.sram_csb  = sram_csb_q;
  assign bus.sram_addr = sram_addr_q;
  assign bus.cfg_bit   = cfg_bit_q;
  assign bus.cfg_shift = cfg_shift_q;
  assign bus.cfg_latch = cfg_latch_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef CFG_CHECKSUM_EN
  assign cfg_err = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_t03_fpga_cfg_streamer.sv
// Scoreboard bench for t03_fpga_cfg_streamer: two instances (SHIFT_DIV 1 and 3) with SRAM models.
module tb_t03_fpga_cfg_streamer;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

`ifdef CFG_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam int K_RD    = 0;
  localparam int K_BIT   = 1;
  localparam int K_LATCH = 2;
  localparam int K_DONE  = 3;

  typedef struct {
    int kind;
    int val;
    int rel;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_a, start_b;
  logic [AW-1:0] saddr_a, saddr_b;
  logic [AW:0]   wc_a, wc_b;
  logic          busy_a, done_a, err_a;
  logic          busy_b, done_b, err_b;

  t03_fpga_cfg_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
  t03_fpga_cfg_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  t03_fpga_cfg_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHIFT_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .start_addr(saddr_a), .word_count(wc_a),
    .bus(bus_a), .busy(busy_a), .done(done_a), .cfg_err(err_a)
  );

  t03_fpga_cfg_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SHIFT_DIV(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .start_addr(saddr_b), .word_count(wc_b),
    .bus(bus_b), .busy(busy_b), .done(done_b), .cfg_err(err_b)
  );

  logic [DW-1:0] mem [0:1023];
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic          rd_pend_a, rd_pend_b;

  // SRAM models: request registered at posedge, dout settles at the following negedge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_a <= 1'b0;
      rd_pend_b <= 1'b0;
    end else begin
      rd_pend_a <= !bus_a.sram_csb;
      rd_pend_b <= !bus_b.sram_csb;
      if (!bus_a.sram_csb) rd_addr_a <= bus_a.sram_addr;
      if (!bus_b.sram_csb) rd_addr_b <= bus_b.sram_addr;
    end
  end

  always @(negedge clk) begin
    if (rd_pend_a) bus_a.sram_dout <= mem[rd_addr_a];
    if (rd_pend_b) bus_b.sram_dout <= mem[rd_addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  evt_t qa[$];
  evt_t qb[$];
  int   t0_a = 0;
  int   t0_b = 0;
  int   total = 0;
  int   bad = 0;

  function automatic void check(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(int unit, int kind, int val, int rel);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    e.rel  = rel;
    if (unit == 0) qa.push_back(e);
    else           qb.push_back(e);
  endfunction

  // Expected event stream for one job: reads, bits, latch/done with cycle offsets from start
  function automatic void push_job(int unit, int div, int addr, int count);
    int            per;
    int            a;
    int            end_rel;
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    per = 2 + 32 * div;
    a   = addr;
    x   = '0;
    for (int i = 0; i < count; i++) begin
      push(unit, K_RD, a, i * per);
      w = mem[a];
      for (int b = 0; b < 32; b++) push(unit, K_BIT, int'(w[31-b]), i * per + 2 + b * div);
      x = x ^ w;
      a = (a + 1) % 1024;
    end
    end_rel = count * per;
    if (count == 0) begin
      push(unit, K_DONE, 0, 0);
    end else if (CHK) begin
      push(unit, K_RD, a, end_rel);
      if (mem[a] == x) begin
        push(unit, K_LATCH, 0, end_rel + 2);
        push(unit, K_DONE, 0, end_rel + 3);
      end else begin
        push(unit, K_DONE, 1, end_rel + 2);
      end
    end else begin
      push(unit, K_LATCH, 0, end_rel);
      push(unit, K_DONE, 0, end_rel + 1);
    end
  endfunction

  function automatic void mon_evt(int unit, int kind, int val);
    evt_t e;
    int   rel;
    int   sz;
    sz  = (unit == 0) ? qa.size() : qb.size();
    rel = cyc - ((unit == 0) ? t0_a : t0_b);
    if (sz == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event u%0d: got kind=%0d val=%0d rel=%0d, expected no event", unit, kind, val, rel);
      return;
    end
    if (unit == 0) e = qa.pop_front();
    else           e = qb.pop_front();
    check($sformatf("evt_kind u%0d", unit), kind, e.kind);
    check($sformatf("evt_val u%0d k%0d", unit, e.kind), val, e.val);
    check($sformatf("evt_time u%0d k%0d", unit, e.kind), rel, e.rel);
  endfunction

  // Monitors sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus_a.sram_csb) mon_evt(0, K_RD, int'(bus_a.sram_addr));
      if (bus_a.cfg_shift) mon_evt(0, K_BIT, int'(bus_a.cfg_bit));
      else                 check("bit_idle_a", int'(bus_a.cfg_bit), 0);
      if (bus_a.cfg_latch) mon_evt(0, K_LATCH, 0);
      if (done_a)          mon_evt(0, K_DONE, int'(err_a));
      if (!bus_b.sram_csb) mon_evt(1, K_RD, int'(bus_b.sram_addr));
      if (bus_b.cfg_shift) mon_evt(1, K_BIT, int'(bus_b.cfg_bit));
      if (bus_b.cfg_latch) mon_evt(1, K_LATCH, 0);
      if (done_b)          mon_evt(1, K_DONE, int'(err_b));
    end
  end

  task automatic start_job(input int unit, input int addr, input int count);
    @(negedge clk);
    if (unit == 0) begin
      start_a = 1'b1; saddr_a = AW'(addr); wc_a = (AW+1)'(count);
      push_job(0, 1, addr, count);
    end else begin
      start_b = 1'b1; saddr_b = AW'(addr); wc_b = (AW+1)'(count);
      push_job(1, 3, addr, count);
    end
    @(posedge clk);
    #1;
    if (unit == 0) begin start_a = 1'b0; t0_a = cyc; end
    else           begin start_b = 1'b0; t0_b = cyc; end
  endtask

  task automatic drain(input int unit, input int limit);
    int n;
    n = 0;
    while (((unit == 0) ? qa.size() : qb.size()) != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check($sformatf("drain_pending u%0d", unit), (unit == 0) ? qa.size() : qb.size(), 0);
    check($sformatf("idle_busy u%0d", unit), int'((unit == 0) ? busy_a : busy_b), 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; saddr_a = '0; wc_a = '0;
    start_b = 1'b0; saddr_b = '0; wc_b = '0;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    mem[5]    = 32'hA500_0001;
    mem[6]    = 32'hA500_0001;
    mem[1023] = 32'h1234_5678;
    mem[0]    = 32'hDEAD_BEEF;
    mem[1]    = 32'hCC99_E897;
    mem[100]  = 32'h0000_FFFF;
    mem[101]  = 32'hFFFF_0000;
    mem[102]  = 32'hFFFF_FFFF;

    repeat (3) @(negedge clk);
    check("rst_csb", int'(bus_a.sram_csb), 1);
    check("rst_addr", int'(bus_a.sram_addr), 0);
    check("rst_shift", int'(bus_a.cfg_shift), 0);
    check("rst_latch", int'(bus_a.cfg_latch), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_err", int'(err_a), 0);
    rst = 1'b0;

    // Single word at address 5
    start_job(0, 5, 1);
    drain(0, 200);

    // Wrap 1023 -> 0, with ignored start pulses while busy
    start_job(0, 1023, 2);
    for (int k = 0; k < 3; k++) begin
      repeat (7) @(negedge clk);
      start_a = 1'b1; saddr_a = AW'(7); wc_a = (AW+1)'(5);
      @(negedge clk);
      start_a = 1'b0;
    end
    drain(0, 300);

    // Zero-length job
    start_job(0, 9, 0);
    drain(0, 20);

    // Divided shift rate on the second instance
    start_job(1, 5, 1);
    drain(1, 400);

    // Checksum match then mismatch
    start_job(0, 100, 2);
    drain(0, 300);
    check("err_after_match", int'(err_a), 0);
    mem[102] = 32'h0000_0000;
    start_job(0, 100, 2);
    drain(0, 300);
    check("err_after_mismatch", int'(err_a), CHK ? 1 : 0);
    start_job(0, 5, 1);
    @(negedge clk);
    check("err_cleared_on_start", int'(err_a), 0);
    drain(0, 200);

    // Reset asserted mid-shift
    start_job(0, 5, 1);
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_csb", int'(bus_a.sram_csb), 1);
    check("midrst_shift", int'(bus_a.cfg_shift), 0);
    check("midrst_busy", int'(busy_a), 0);
    qa.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst_no_events", qa.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
